// File: rtl/hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl
//
// Hazard and stall controller for the 5-stage MIPS core. It works alongside the
// EX-stage forwarding logic and catches the hazards forwarding cannot cover:
//   - load-use: a load in EX feeds an instruction in ID
//   - branch-in-ID: a branch compares registers that an EX instruction is
//     still producing
// It inserts ID/EX bubbles, flushes IF/ID on a taken branch and freezes the
// whole pipe while either cache is missing. Every control output is Mealy,
// meaning it is decoded in the same cycle from the current state and inputs.
//
// Parameters
//   AW            register-specifier width
//   LD_BR_BUBBLES bubbles for a load feeding a branch in ID (>= 1)
//   CNT_W         perf-counter width (only used with HAZARD_PERF_CNT_EN)
//
// Ports
//   clk, rst        rising-edge clock; asynchronous active-high reset
//   if_id_rs/rt     source registers of the instruction in ID
//   if_id_branch    ID instruction is beq/bne
//   branch_taken    ID branch comparator result
//   id_ex_wr_reg    destination register of the EX instruction
//   id_ex_reg_w     EX instruction writes the register file
//   id_ex_mem_read  EX instruction is a load
//   icache_stall    I-cache miss in progress
//   dcache_stall    D-cache miss in progress
//   pc_en           PC write enable
//   if_id_en        IF/ID write enable
//   if_id_flush     clears IF/ID to a NOP
//   id_ex_en        ID/EX write enable
//   id_ex_bubble    ID/EX loads a NOP (control fields zeroed)
//   ex_mem_en       EX/MEM write enable
//   mem_wb_en       MEM/WB write enable
//
// Configuration macro
//   HAZARD_PERF_CNT_EN  adds the saturating counters stall_cyc_cnt,
//                       bubble_cyc_cnt and flush_cnt (CNT_W bits each).
// -----------------------------------------------------------------------------
module hazard_stall_ctrl #(
   parameter int AW            = 5,
   parameter int LD_BR_BUBBLES = 2,
   parameter int CNT_W         = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] if_id_rs,
   input  logic [AW-1:0] if_id_rt,
   input  logic          if_id_branch,
   input  logic          branch_taken,
   input  logic [AW-1:0] id_ex_wr_reg,
   input  logic          id_ex_reg_w,
   input  logic          id_ex_mem_read,
   input  logic          icache_stall,
   input  logic          dcache_stall,
   output logic          pc_en,
   output logic          if_id_en,
   output logic          if_id_flush,
   output logic          id_ex_en,
   output logic          id_ex_bubble,
   output logic          ex_mem_en,
   output logic          mem_wb_en
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] stall_cyc_cnt,
   output logic [CNT_W-1:0] bubble_cyc_cnt,
   output logic [CNT_W-1:0] flush_cnt
`endif
);

   localparam int BW = $clog2(LD_BR_BUBBLES + 1);

   // Reject configurations that cannot work, at elaboration time.
   if (LD_BR_BUBBLES < 1 || CNT_W < 1) begin : gBadParam
      $error("hazard_stall_ctrl: LD_BR_BUBBLES and CNT_W must both be >= 1");
   end

   typedef enum logic {RUN, BUBBLE} stateType;

   stateType      state, stateNext;
   logic [BW-1:0] bubLeft, bubLeftNext;

   logic memStall;
   logic regMatch;
   logic loadUse;
   logic aluBranch;
   logic issueBubble;
   logic takeFlush;

   assign memStall  = icache_stall | dcache_stall;
   // Register $0 is hard-wired to zero, so a write to it is never a dependence.
   assign regMatch  = (id_ex_wr_reg != '0) &&
                      ((id_ex_wr_reg == if_id_rs) || (id_ex_wr_reg == if_id_rt));
   assign loadUse   = id_ex_mem_read && regMatch;
   // An ALU result is forwarded only into EX, so a branch resolved in ID must wait.
   assign aluBranch = id_ex_reg_w && !id_ex_mem_read && regMatch && if_id_branch;

   // A freeze overrides everything. While a bubble is issued the branch operands
   // are stale, so branch_taken is ignored and the branch is re-evaluated later.
   assign issueBubble = !memStall && ((state == BUBBLE) || loadUse || aluBranch);
   assign takeFlush   = !memStall && (state == RUN) && !loadUse && !aluBranch &&
                        if_id_branch && branch_taken;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= RUN;
         bubLeft <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments. Every flop then
         // samples its pre-edge value, whatever order the blocks are evaluated in.
         state   <= stateNext;
         bubLeft <= bubLeftNext;
      end
   end

   // Next-state logic
   always_comb begin
      // NOTE: give every combinational output a default before any branch.
      // Otherwise a path that skips the assignment infers a latch.
      stateNext   = state;
      bubLeftNext = bubLeft;
      if (!memStall) begin
         unique case (state)
            BUBBLE: begin
               bubLeftNext = bubLeft - BW'(1);
               if (bubLeft <= BW'(1)) stateNext = RUN;
            end
            RUN: begin
               // The first bubble of a load->branch stall goes out this cycle.
               // The rest are counted down in BUBBLE.
               if (loadUse && if_id_branch && (LD_BR_BUBBLES > 1)) begin
                  stateNext   = BUBBLE;
                  bubLeftNext = BW'(LD_BR_BUBBLES - 1);
               end
            end
            default: begin
               stateNext   = RUN;
               bubLeftNext = '0;
            end
         endcase
      end
   end

   // Output logic (Mealy). While reset is asserted, everything is held low.
   always_comb begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_en     = 1'b0;
      id_ex_bubble = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      if (!rst && !memStall) begin
         id_ex_en  = 1'b1;
         ex_mem_en = 1'b1;
         mem_wb_en = 1'b1;
         if (issueBubble) begin
            id_ex_bubble = 1'b1;
         end else begin
            pc_en       = 1'b1;
            if_id_en    = 1'b1;
            if_id_flush = takeFlush;
         end
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   // Saturating performance counters: freeze cycles, bubble cycles, flushes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cyc_cnt  <= '0;
         bubble_cyc_cnt <= '0;
         flush_cnt      <= '0;
      end else begin
         if (memStall && (stall_cyc_cnt != '1))
            stall_cyc_cnt <= stall_cyc_cnt + CNT_W'(1);
         if (id_ex_bubble && (bubble_cyc_cnt != '1))
            bubble_cyc_cnt <= bubble_cyc_cnt + CNT_W'(1);
         if (if_id_flush && (flush_cnt != '1))
            flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_stall_ctrl
//
// Self-checking bench for hazard_stall_ctrl. A reference model tracks how many
// stall bubbles are still owed as a plain integer. It is evaluated at each
// negedge against the DUT's Mealy outputs. Directed scenarios run first, then
// a randomized stretch.
// -----------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

   localparam int AW  = 5;
   localparam int LDB = 2;
   localparam int CW  = 32;

   // Output vector order: {pc_en, if_id_en, if_id_flush, id_ex_en,
   //                       id_ex_bubble, ex_mem_en, mem_wb_en}
   localparam logic [6:0] CTL_RUN    = 7'b1101011;
   localparam logic [6:0] CTL_BUB    = 7'b0001111;
   localparam logic [6:0] CTL_FLUSH  = 7'b1111011;
   localparam logic [6:0] CTL_FREEZE = 7'b0000000;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] if_id_rs, if_id_rt, id_ex_wr_reg;
   logic          if_id_branch, branch_taken, id_ex_reg_w, id_ex_mem_read;
   logic          icache_stall, dcache_stall;
   logic          pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble;
   logic          ex_mem_en, mem_wb_en;
`ifdef HAZARD_PERF_CNT_EN
   logic [CW-1:0] stall_cyc_cnt, bubble_cyc_cnt, flush_cnt;
`endif

   always #5 clk = ~clk;

   hazard_stall_ctrl #(
      .AW(AW), .LD_BR_BUBBLES(LDB), .CNT_W(CW)
   ) dut (
      .clk(clk), .rst(rst),
      .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
      .if_id_branch(if_id_branch), .branch_taken(branch_taken),
      .id_ex_wr_reg(id_ex_wr_reg), .id_ex_reg_w(id_ex_reg_w),
      .id_ex_mem_read(id_ex_mem_read),
      .icache_stall(icache_stall), .dcache_stall(dcache_stall),
      .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
      .id_ex_en(id_ex_en), .id_ex_bubble(id_ex_bubble),
      .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en)
`ifdef HAZARD_PERF_CNT_EN
      ,
      .stall_cyc_cnt(stall_cyc_cnt), .bubble_cyc_cnt(bubble_cyc_cnt),
      .flush_cnt(flush_cnt)
`endif
   );

   logic [6:0] ctl;
   assign ctl = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en, mem_wb_en};

   int testCount = 0;
   int failCount = 0;

   // Reference model state
   int pending = 0;   // bubbles still owed after the current cycle
   int nStall  = 0;
   int nBubble = 0;
   int nFlush  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      testCount++;
      if (got !== exp) begin
         failCount++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: apply inputs at the negedge, then compare the DUT's Mealy
   // outputs with the model and advance the model to the coming posedge.
   task automatic step(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                       input logic [AW-1:0] wr, input logic br, input logic tk,
                       input logic regw, input logic mr, input logic ic, input logic dc);
      logic [6:0] exp;
      bit hit;
      @(negedge clk);
      if_id_rs = rs; if_id_rt = rt; id_ex_wr_reg = wr;
      if_id_branch = br; branch_taken = tk;
      id_ex_reg_w = regw; id_ex_mem_read = mr;
      icache_stall = ic; dcache_stall = dc;
      #1;
      hit = (wr != 0) && (wr == rs || wr == rt);
      if (ic || dc) begin
         exp = CTL_FREEZE; nStall++;
      end else if (pending > 0) begin
         exp = CTL_BUB; nBubble++; pending--;
      end else if (mr && hit) begin
         exp = CTL_BUB; nBubble++;
         if (br) pending = LDB - 1;
      end else if (regw && hit && br) begin
         exp = CTL_BUB; nBubble++;
      end else if (br && tk) begin
         exp = CTL_FLUSH; nFlush++;
      end else begin
         exp = CTL_RUN;
      end
      check("ctl", 32'(ctl), 32'(exp));
   endtask

   task automatic checkCounters(input string tag);
`ifdef HAZARD_PERF_CNT_EN
      check({tag, "_stall_cnt"},  stall_cyc_cnt,  32'(nStall));
      check({tag, "_bubble_cnt"}, bubble_cyc_cnt, 32'(nBubble));
      check({tag, "_flush_cnt"},  flush_cnt,      32'(nFlush));
`else
      check({tag, "_no_flush_bubble"}, 32'(if_id_flush & id_ex_bubble), 32'(0));
`endif
   endtask

   initial begin
      rst = 1'b1;
      if_id_rs = '0; if_id_rt = '0; id_ex_wr_reg = '0;
      if_id_branch = 0; branch_taken = 0; id_ex_reg_w = 0; id_ex_mem_read = 0;
      icache_stall = 0; dcache_stall = 0;
      #3;
      check("rst_ctl", 32'(ctl), 32'(CTL_FREEZE));
      checkCounters("rst");
      @(negedge clk);
      rst = 1'b0;

      // Load-use: one bubble, then normal flow.
      step(8, 0, 8, 0, 0, 1, 1, 0, 0); check("T1_bubble", 32'(ctl), 32'(CTL_BUB));
      step(8, 0, 8, 0, 0, 1, 0, 0, 0); check("T1_release", 32'(ctl), 32'(CTL_RUN));

      // Load -> branch: two bubbles, then the taken branch flushes.
      step(0, 9, 9, 1, 1, 1, 1, 0, 0); check("T2_bub1", 32'(ctl), 32'(CTL_BUB));
      step(0, 9, 0, 1, 1, 0, 0, 0, 0); check("T2_bub2", 32'(ctl), 32'(CTL_BUB));
      step(0, 9, 0, 1, 1, 0, 0, 0, 0); check("T2_flush", 32'(ctl), 32'(CTL_FLUSH));

      // ALU -> branch: exactly one bubble.
      step(10, 0, 10, 1, 1, 1, 0, 0, 0); check("T3_bubble", 32'(ctl), 32'(CTL_BUB));
      step(10, 0, 0, 1, 0, 0, 0, 0, 0);  check("T3_run", 32'(ctl), 32'(CTL_RUN));

      // D-cache freeze entering the second bubble; that bubble resumes afterwards.
      step(0, 9, 9, 1, 1, 1, 1, 0, 0); check("T4_bub1", 32'(ctl), 32'(CTL_BUB));
      for (int i = 0; i < 3; i++) begin
         step(0, 9, 0, 1, 1, 0, 0, 0, 1); check("T4_freeze", 32'(ctl), 32'(CTL_FREEZE));
      end
      step(0, 9, 0, 1, 1, 0, 0, 0, 0); check("T4_bub2", 32'(ctl), 32'(CTL_BUB));
      step(0, 9, 0, 1, 1, 0, 0, 0, 0); check("T4_after", 32'(ctl), 32'(CTL_FLUSH));

      // A write to $0 is never a hazard.
      step(0, 0, 0, 0, 0, 1, 1, 0, 0); check("T5_nobub", 32'(ctl), 32'(CTL_RUN));
      step(0, 0, 0, 1, 1, 1, 1, 0, 0); check("T5_flush", 32'(ctl), 32'(CTL_FLUSH));
      checkCounters("dir");

      // Asynchronous reset between edges while in BUBBLE.
      step(0, 9, 9, 1, 1, 1, 1, 0, 0); check("T6_bub1", 32'(ctl), 32'(CTL_BUB));
      @(posedge clk);
      #2 rst = 1'b1;
      #1 check("T6_rst", 32'(ctl), 32'(CTL_FREEZE));
      pending = 0; nStall = 0; nBubble = 0; nFlush = 0;
      checkCounters("T6");
      if_id_branch = 0; branch_taken = 0; id_ex_mem_read = 0; id_ex_reg_w = 0;
      id_ex_wr_reg = '0;
      @(negedge clk);
      rst = 1'b0;
      // Still in BUBBLE, this cycle would bubble instead of flushing.
      step(0, 9, 0, 1, 1, 0, 0, 0, 0); check("T6_run", 32'(ctl), 32'(CTL_FLUSH));

      // Randomized traffic over a small register set, so that matches are frequent.
      for (int n = 0; n < 3000; n++) begin
         step(AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
              ($urandom_range(0, 9) < 4), $urandom_range(0, 1) == 1,
              ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 3),
              ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
         if (n % 500 == 499) checkCounters("rand");
      end
      checkCounters("final");

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
